// File: rtl/uart_rx_frame_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive framer.
//   rx_state_t     : receive FSM states
//   UART_DATA_BITS : default number of data bits per character
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam int UART_DATA_BITS = 8;

endpackage

// File: rtl/uart_rx_frame_if.sv
// ---------------------------------------------------------------------------
// uart_rx_frame_if
// Character delivery bus from the UART receive framer to the command layer.
//   rx_data    : last good character, held until the next good frame
//   rx_valid   : one-cycle pulse, rx_data has just been updated
//   frame_err  : one-cycle pulse, stop bit sampled low
//   parity_err : one-cycle pulse, parity mismatch (0 when parity is absent)
// Modports: master = framer (drives), slave = consumer.
// ---------------------------------------------------------------------------
interface uart_rx_frame_if
    import uart_pkg::*;
#(
    parameter int DATA_BITS = UART_DATA_BITS
);

    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 frame_err;
    logic                 parity_err;

    modport master (
        output rx_data,
        output rx_valid,
        output frame_err,
        output parity_err
    );

    modport slave (
        input rx_data,
        input rx_valid,
        input frame_err,
        input parity_err
    );

endinterface

// File: rtl/uart_rx_frame_sync.sv
// ---------------------------------------------------------------------------
// rx_sync_edge
// Brings the asynchronous serial line into the clk domain through two flops,
// then keeps a third flop of history to find falling edges. All flops reset
// to 1 (idle line) so that leaving reset never looks like a start edge.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   din      : raw asynchronous input
//   level    : synchronised line level
//   fall     : one-cycle pulse, synchronised level went 1 -> 0
// ---------------------------------------------------------------------------
module rx_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic fall
);

    logic sync_p0;
    logic sync_p1;
    logic prev_p2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
            prev_p2 <= 1'b1;
        end else begin
            sync_p0 <= din;
            sync_p1 <= sync_p0;
            prev_p2 <= sync_p1;
        end
    end

    assign level = sync_p1;
    assign fall  = prev_p2 & ~sync_p1;

endmodule

// File: rtl/uart_rx_frame.sv
// ---------------------------------------------------------------------------
// uart_rx_frame
// UART receive framer. Detects a start edge on rxd, enables the external baud
// tick generator (bps_start), samples start/data/(parity)/stop bits on the
// mid-bit tick clk_bps and reports each character on the delivery bus.
// Data bits arrive LSB first.
// Build option: define UART_RX_PARITY_EN to expect one even-parity bit after
// the data bits; otherwise parity_err is tied to 0.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   rxd       : raw serial line, idle high, asynchronous
//   clk_bps   : one-cycle mid-bit sample tick
//   bps_start : enables the tick generator while a frame is in progress
//   bus       : delivery bus (rx_data, rx_valid, frame_err, parity_err)
// ---------------------------------------------------------------------------
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int DATA_BITS = UART_DATA_BITS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rxd,
    input  logic                   clk_bps,
    output logic                   bps_start,
    uart_rx_frame_if.master        bus
);

    localparam int CNT_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_BITS - 1);

    logic                 line_lvl;
    logic                 line_fall;

    rx_state_t            state;
    logic [CNT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 ferr_q;
    logic                 perr_q;
    logic                 par_bad;

    rx_sync_edge u_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (rxd),
        .level (line_lvl),
        .fall  (line_fall)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            bps_start <= 1'b0;
            bit_cnt   <= '0;
            shreg     <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            perr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad   <= 1'b0;
`endif
        end else begin
            // Status outputs are single-cycle pulses.
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            perr_q  <= 1'b0;
            case (state)
                IDLE: begin
                    // Ticks are ignored here; only a fresh falling edge starts
                    // a frame, so a stuck-low line cannot re-trigger.
                    if (line_fall) begin
                        state     <= START;
                        bps_start <= 1'b1;
                    end
                end
                START: begin
                    if (clk_bps) begin
                        if (!line_lvl) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end else begin
                            // Line already high at mid start bit: a glitch.
                            state     <= IDLE;
                            bps_start <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    if (clk_bps) begin
                        shreg   <= {line_lvl, shreg[DATA_BITS-1:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == CNT_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (clk_bps) begin
                        // Even parity: data bits plus parity bit XOR to 0.
                        par_bad <= ^{line_lvl, shreg};
                        state   <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (clk_bps) begin
                        state     <= IDLE;
                        bps_start <= 1'b0;
                        if (line_lvl && !par_bad) begin
                            data_q  <= shreg;
                            valid_q <= 1'b1;
                        end
                        ferr_q <= ~line_lvl;
                        perr_q <= par_bad;
                    end
                end
                default: begin
                    state     <= IDLE;
                    bps_start <= 1'b0;
                end
            endcase
        end
    end

`ifndef UART_RX_PARITY_EN
    assign par_bad = 1'b0;
`endif

    assign bus.rx_data    = data_q;
    assign bus.rx_valid   = valid_q;
    assign bus.frame_err  = ferr_q;
    assign bus.parity_err = perr_q;

endmodule

// File: doc/uart_rx_frame.md
# uart_rx_frame

UART receive framer; consumes the one-cycle mid-bit sampling tick `clk_bps` from the baud tick generator and drives that generator's `bps_start` enable. Synchronises the raw serial input, detects start bits, shifts in LSB-first data and checks the stop bit (plus optional parity). Delivers each received character to the command-handler layer as a one-cycle valid pulse.

## Interface
- `DATA_BITS`, 8: data bits per frame, legal range 5..8.
- `clk`  in  1  system clock, the same clock as the baud tick generator.
- `rst`  in  1  asynchronous, active-high reset.
- `rxd`  in  1  raw serial line. Asynchronous to `clk`. Idle high.
- `clk_bps`  in  1  one-cycle sample tick from the baud tick generator, at mid-bit.
- `bps_start`  out  1  enables the baud tick generator while a frame is in progress.
- `rx_data`  out  DATA_BITS  last received character. Held until the next valid frame.
- `rx_valid`  out  1  one-cycle pulse: `rx_data` has just been updated.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `parity_err`  out  1  one-cycle pulse: parity mismatch. Constant 0 when parity is compiled out.

## Operation
- Input conditioning:
  - `rxd` passes through a 2-flop synchroniser, then a third flop for edge detection.
  - All three flops reset to 1.
  - Start condition: synchronised value is 0 and the previous value is 1.
- Tick behaviour: once `bps_start` rises, the first `clk_bps` lands at the middle of the start bit. Subsequent ticks arrive one bit period apart.
- FSM states:
  - IDLE: `bps_start`=0. On a falling edge → START and set `bps_start`=1.
  - START: on a tick, if the synchronised line is 0 → DATA with bit counter = 0. If the line is 1 → IDLE (glitch rejected, no error pulse).
  - DATA: on each tick, shift the synchronised bit in LSB-first (shift right, new bit at MSB) and increment the counter. After DATA_BITS ticks → PARITY if enabled, else STOP.
  - PARITY: on a tick, latch the parity-check result → STOP.
  - STOP: on a tick, clear `bps_start` and → IDLE.
    - Line 1 and no parity error: copy the shift register to `rx_data` and pulse `rx_valid`.
    - Line 0: pulse `frame_err`; `rx_data` unchanged.
    - Parity error with good stop bit: pulse `parity_err`; `rx_data` unchanged, no `rx_valid`.
    - Both faults: `frame_err` and `parity_err` pulse together.
- Break or stuck-low line after a frame error: no re-trigger until the line returns high and falls again.
- `clk_bps` pulses arriving in IDLE are ignored.

## Timing
- Reset values:
  - `bps_start`=0, `rx_data`=0, `rx_valid`=0, `frame_err`=0, `parity_err`=0.
  - FSM in IDLE, counter and shift register cleared.
  - Reset mid-frame aborts the frame silently.
- `bps_start` rises 1 cycle after the synchronised falling edge, i.e. 3 `clk` cycles after the `rxd` transition.
- `rx_valid` / `frame_err` / `parity_err` are registered and asserted in the cycle after the stop-bit tick. Exactly one cycle wide.
- `bps_start` falls in the same cycle the status pulse asserts.
- A new start edge is accepted from the first cycle back in IDLE. Back-to-back frames with a single stop bit are supported.
- Bit counter width is `$clog2(DATA_BITS+1)`. It never wraps; its terminal value equals DATA_BITS.

## Configuration
- `UART_RX_PARITY_EN` defined: one even-parity bit follows the data bits.
  - Check: XOR of the data bits and the parity bit must be 0.
  - The PARITY state exists.
- Not defined: PARITY state, parity logic and register removed; `parity_err` tied to 0; frame = start + DATA_BITS + stop.

## Structure
- Shared package `uart_pkg`:
  - FSM state enum `rx_state_t` (IDLE, START, DATA, PARITY, STOP).
  - Default data width constant `UART_DATA_BITS` = 8.
- One sub-module, `rx_sync_edge`: 3-flop synchroniser with reset-to-1. Outputs the synchronised level and the falling-edge pulse.

## Test plan
- Tick generator with 50 MHz `clk` at 9600 baud; send 0xA5 (8N1) → `rx_data`=0xA5, single `rx_valid` pulse, no error pulses, `bps_start` low afterwards.
- `rxd` low pulse of 1 µs (shorter than half a bit) → START rejects it, returns to IDLE; no pulses, `rx_data` unchanged.
- 0x3C sent with the stop bit forced low → `frame_err` pulse, no `rx_valid`; `rx_data` keeps its prior value; line then held low for 20 bits → no new frame.
- 0x00 then 0xFF back-to-back with one stop bit each → two `rx_valid` pulses, values in order.
- `UART_RX_PARITY_EN`: 0x07 with parity bit 0 (should be 1) → `parity_err` pulse, no `rx_valid`; with correct parity → `rx_valid`, `rx_data`=0x07.
- `rst` asserted during the 4th data bit, then released before a fresh 0x5A frame → all outputs at reset values during reset; 0x5A received cleanly.
